// File: rtl/alu_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : alu_sequencer                                              |
// | Description : Initiator side of the ALU interface. Accepts one command   |
// |               (opcode + two operands) over a valid/ready handshake,      |
// |               strobes the ALU for one cycle, waits the ALU's fixed       |
// |               latency, captures the result and returns it on a           |
// |               valid/ready response channel.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock            in   1         system clock, rising edge             |
// |   reset            in   1         synchronous, active-high reset        |
// |   cmd_valid        in   1         command present                       |
// |   cmd_ready        out  1         sequencer can accept a command        |
// |   cmd_op           in   OP_WIDTH  ALU opcode                            |
// |   cmd_a / cmd_b    in   WIDTH     operands                              |
// |   alu_enable       out  1         one-cycle ALU enable strobe           |
// |   alu_a / alu_b    out  WIDTH     operands to the ALU                   |
// |   alu_control_bus  out  OP_WIDTH  opcode to the ALU                     |
// |   alu_outp         in   WIDTH     ALU result                            |
// |   rsp_valid        out  1         result available                      |
// |   rsp_ready        in   1         consumer takes the result             |
// |   rsp_data         out  WIDTH     captured ALU result                   |
// |   rsp_op           out  OP_WIDTH  opcode that produced rsp_data         |
// |   busy             out  1         high in any state other than IDLE     |
// |   op_count         out  8         completed responses, wraps            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int OP_WIDTH    = 3,
  // Legal range 1..15; the wait counter is four bits wide.
  parameter int ALU_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_WIDTH-1:0] cmd_op,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  output logic                alu_enable,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_WIDTH-1:0] alu_control_bus,
  input  logic [WIDTH-1:0]    alu_outp,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic [OP_WIDTH-1:0] rsp_op,
  output logic                busy,
  output logic [7:0]          op_count
);

  localparam logic [3:0] c_LATENCY = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic                  alu_enable_q;
  logic [WIDTH-1:0]      alu_a_q;
  logic [WIDTH-1:0]      alu_b_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic                  rsp_valid_q;
  logic [WIDTH-1:0]      rsp_data_q;
  logic [OP_WIDTH-1:0]   rsp_op_q;
  logic [7:0]            op_count_q;

  assign cnt_d = cnt_q - 4'd1;

  // The counter is loaded with the latency at accept and decremented once in
  // ISSUE and once per WAIT edge that does not capture. Capture happens on
  // the WAIT edge that finds it at zero, which is edge 1+ALU_LATENCY after
  // accept. For ALU_LATENCY=1 that is the single cycle following ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_enable_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_op_q     <= '0;
      op_count_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a_q      <= cmd_a;
            alu_b_q      <= cmd_b;
            alu_op_q     <= cmd_op;
            alu_enable_q <= 1'b1;
            cnt_q        <= c_LATENCY;
            state_q      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          alu_enable_q <= 1'b0;
          cnt_q        <= cnt_d;
          state_q      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= alu_outp;
            rsp_op_q    <= alu_op_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // cmd_ready is masked by reset so no command is taken while reset is held,
  // even though the state register already reads IDLE after the first edge.
  assign cmd_ready       = (state_q == ST_IDLE) && !reset;
  assign busy            = (state_q != ST_IDLE);

  assign alu_enable      = alu_enable_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_control_bus = alu_op_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_op          = rsp_op_q;
  assign op_count        = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_sequencer                                           |
// | Description : Self-checking bench for alu_sequencer. Two instances,      |
// |               ALU_LATENCY=1 and ALU_LATENCY=3, each driving an ALU stub  |
// |               whose result pipeline is exactly the latency deep.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_alu_sequencer;

  localparam int W  = 8;
  localparam int OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst;
  logic [1:0]          cmd_valid;
  logic [1:0]          cmd_ready;
  logic [1:0]          alu_enable;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [1:0]          busy;
  logic [1:0][OW-1:0]  cmd_op;
  logic [1:0][OW-1:0]  alu_cb;
  logic [1:0][OW-1:0]  rsp_op;
  logic [1:0][W-1:0]   cmd_a;
  logic [1:0][W-1:0]   cmd_b;
  logic [1:0][W-1:0]   alu_a;
  logic [1:0][W-1:0]   alu_b;
  logic [1:0][W-1:0]   alu_outp;
  logic [1:0][W-1:0]   rsp_data;
  logic [1:0][7:0]     op_count;

  // ALU behaviour used by the stub and by the expected-result model.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 3;
      logic [7:0] pipe [L];

      // Result enters the pipe on the edge that sees alu_enable=1 and is
      // readable L edges later; anything else is poisoned with 8'hEE.
      always @(posedge clk) begin
        pipe[0] <= alu_enable[g] ? alu_f(alu_cb[g], alu_a[g], alu_b[g]) : 8'hEE;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign alu_outp[g] = pipe[L-1];

      alu_sequencer #(.WIDTH(W), .OP_WIDTH(OW), .ALU_LATENCY(L)) u_dut (
        .clock           (clk),
        .reset           (rst[g]),
        .cmd_valid       (cmd_valid[g]),
        .cmd_ready       (cmd_ready[g]),
        .cmd_op          (cmd_op[g]),
        .cmd_a           (cmd_a[g]),
        .cmd_b           (cmd_b[g]),
        .alu_enable      (alu_enable[g]),
        .alu_a           (alu_a[g]),
        .alu_b           (alu_b[g]),
        .alu_control_bus (alu_cb[g]),
        .alu_outp        (alu_outp[g]),
        .rsp_valid       (rsp_valid[g]),
        .rsp_ready       (rsp_ready[g]),
        .rsp_data        (rsp_data[g]),
        .rsp_op          (rsp_op[g]),
        .busy            (busy[g]),
        .op_count        (op_count[g])
      );
    end
  endgenerate

  int tests = 0;
  int fails = 0;
  int model_cnt [2];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d]       = 1'b1;
    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset cmd_ready", cmd_ready[d], 0);
    check("reset alu_enable", alu_enable[d], 0);
    check("reset alu_a", alu_a[d], 0);
    check("reset alu_cb", alu_cb[d], 0);
    check("reset rsp_valid", rsp_valid[d], 0);
    check("reset rsp_data", rsp_data[d], 0);
    check("reset rsp_op", rsp_op[d], 0);
    check("reset op_count", op_count[d], 0);
    check("reset busy", busy[d], 0);
    rst[d] = 1'b0;
    @(negedge clk);
    check("post-reset cmd_ready", cmd_ready[d], 1);
    model_cnt[d] = 0;
  endtask

  task automatic wait_ready(input int d);
    int k = 0;
    while (cmd_ready[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready before issue", cmd_ready[d], 1);
  endtask

  // One complete command: accept, strobe, latency, optional backpressure,
  // handoff. Called at a negedge; returns at the negedge after handoff.
  task automatic run_cmd(input int d, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input logic [7:0] exp);
    int k;
    wait_ready(d);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    rsp_ready[d] = (hold == 0);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    check("issue alu_enable", alu_enable[d], 1);
    check("issue alu_a", alu_a[d], a);
    check("issue alu_b", alu_b[d], b);
    check("issue alu_cb", alu_cb[d], op);
    check("issue cmd_ready", cmd_ready[d], 0);
    check("issue busy", busy[d], 1);
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) check("enable one cycle", alu_enable[d], 0);
    end
    check("rsp latency", k, 1 + lat_of(d));
    check("rsp_data", rsp_data[d], exp);
    check("rsp_op", rsp_op[d], op);
    for (int i = 0; i < hold; i++) begin
      check("bp rsp_valid", rsp_valid[d], 1);
      check("bp rsp_data", rsp_data[d], exp);
      check("bp cmd_ready", cmd_ready[d], 0);
      check("bp op_count", op_count[d], model_cnt[d]);
      @(negedge clk);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    model_cnt[d] = (model_cnt[d] + 1) % 256;
    check("handoff rsp_valid", rsp_valid[d], 0);
    check("handoff op_count", op_count[d], model_cnt[d]);
    check("handoff cmd_ready", cmd_ready[d], 1);
  endtask

  // A second command is held valid while the first is in flight; it must be
  // taken only on the first IDLE edge and must not disturb alu_a before that.
  task automatic ignored_test(input int d);
    int k;
    wait_ready(d);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = 3'd0;
    cmd_a[d]     = 8'h10;
    cmd_b[d]     = 8'h20;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    cmd_a[d] = 8'hFF;
    cmd_b[d] = 8'h01;
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      check("ign alu_a held", alu_a[d], 8'h10);
      check("ign cmd_ready", cmd_ready[d], 0);
      @(negedge clk);
      k++;
    end
    check("ign first latency", k, 1 + lat_of(d));
    check("ign first data", rsp_data[d], 8'h30);
    @(negedge clk);
    model_cnt[d] = (model_cnt[d] + 1) % 256;
    check("ign first count", op_count[d], model_cnt[d]);
    check("ign idle cmd_ready", cmd_ready[d], 1);
    check("ign alu_a before accept", alu_a[d], 8'h10);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    check("ign second accepted", alu_a[d], 8'hFF);
    check("ign second enable", alu_enable[d], 1);
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ign second latency", k, 1 + lat_of(d));
    check("ign second data", rsp_data[d], 8'h00);
    @(negedge clk);
    model_cnt[d] = (model_cnt[d] + 1) % 256;
    check("ign second count", op_count[d], model_cnt[d]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ign no extra rsp", rsp_valid[d], 0);
      check("ign no extra accept", busy[d], 0);
    end
  endtask

  task automatic reset_mid_wait(input int d);
    wait_ready(d);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = 3'd0;
    cmd_a[d]     = 8'h10;
    cmd_b[d]     = 8'h20;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    rst[d]       = 1'b1;
    @(negedge clk);
    check("rmid alu_enable", alu_enable[d], 0);
    check("rmid rsp_valid", rsp_valid[d], 0);
    check("rmid op_count", op_count[d], 0);
    check("rmid busy", busy[d], 0);
    check("rmid cmd_ready in reset", cmd_ready[d], 0);
    rst[d] = 1'b0;
    model_cnt[d] = 0;
    @(negedge clk);
    check("rmid cmd_ready after", cmd_ready[d], 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rmid no stale rsp", rsp_valid[d], 0);
    end
  endtask

  initial begin
    rst       = 2'b11;
    cmd_valid = '0;
    rsp_ready = '0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;

    vecs[0]  = '{3'd0, 8'h01, 8'h02, 0, 8'h03};
    vecs[1]  = '{3'd0, 8'h01, 8'h02, 5, 8'h03};
    vecs[2]  = '{3'd0, 8'h10, 8'h20, 0, 8'h30};
    vecs[3]  = '{3'd1, 8'h05, 8'h03, 1, 8'h02};
    vecs[4]  = '{3'd1, 8'h00, 8'h01, 0, 8'hFF};
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 2, 8'h30};
    vecs[6]  = '{3'd3, 8'hF0, 8'h0F, 0, 8'hFF};
    vecs[7]  = '{3'd4, 8'hAA, 8'hFF, 0, 8'h55};
    vecs[8]  = '{3'd5, 8'h0F, 8'h00, 0, 8'hF0};
    vecs[9]  = '{3'd6, 8'h81, 8'h00, 0, 8'h02};
    vecs[10] = '{3'd7, 8'h81, 8'h00, 3, 8'h40};

    do_reset(0);
    do_reset(1);

    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 11; v++)
        run_cmd(d, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].hold, vecs[v].exp);
    end

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
        run_cmd(d, op, a, b, $urandom_range(0, 3), alu_f(op, a, b));
      end
    end

    ignored_test(0);
    ignored_test(1);
    reset_mid_wait(1);
    run_cmd(1, 3'd0, 8'h10, 8'h20, 0, 8'h30);

    do_reset(0);
    for (int n = 1; n <= 256; n++) begin
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      run_cmd(0, op, a, b, $urandom_range(0, 1), alu_f(op, a, b));
      if (n == 255) check("wrap count 255", op_count[0], 8'hFF);
      if (n == 256) check("wrap count 256", op_count[0], 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
